// File: rtl/psum_accum.sv
// psum_accum: partial-sum accumulator that sits directly behind the PE.
//
// The block takes a scattered stream of (position, signed product) pairs and
// accumulates each product into an on-chip output-feature buffer. It uses a
// two-stage read-modify-write pipeline with forwarding, so back-to-back
// products to one position accumulate exactly and never stall. On a drain
// command it streams the finished tile out in position order over valid/ready.
// Each entry is zeroed as it is handed off, so the next tile starts clean.
//
// Ports
//   i_clk        clock (rising edge only)
//   i_rst_n      asynchronous active-low reset
//   i_valid      product valid
//   i_pos        product target position
//   i_data       signed product (DATA_W)
//   o_ready      product accepted when i_valid && o_ready (ACCUM only)
//   i_clear      pulse: zero the whole buffer
//   i_drain      pulse: stream out the tile, then zero it
//   o_out_valid  drain beat valid
//   o_out_pos    drain beat position
//   o_out_data   drain beat accumulated value (signed ACC_W)
//   i_out_ready  consumer ready
//   o_busy       high while clearing, flushing or draining
//   o_done       one-cycle pulse when a clear or a drain completes
module psum_accum #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_pos,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  input  logic              i_clear,
  input  logic              i_drain,
  output logic              o_out_valid,
  output logic [ADDR_W-1:0] o_out_pos,
  output logic [ACC_W-1:0]  o_out_data,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_POS  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FETCH_END = (ADDR_W + 1)'(DEPTH);
  localparam logic [ACC_W-1:0]  ACC_MAX   = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic [ACC_W-1:0]  ACC_MIN   = {1'b1, {(ACC_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_ACCUM,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  // Clear address walker
  logic [ADDR_W-1:0] clr_addr_reg;

  // RMW stage 2 registers
  logic              s2_valid_reg;
  logic [ADDR_W-1:0] s2_pos_reg;
  logic [DATA_W-1:0] s2_data_reg;
  logic              fwd_reg;
  logic [ACC_W-1:0]  fwd_data_reg;

  // Drain fetch / output stage
  logic [ADDR_W:0]   fetch_cnt_reg;
  logic              pend_reg;
  logic [ADDR_W-1:0] pend_pos_reg;
  logic              out_valid_reg;
  logic [ADDR_W-1:0] out_pos_reg;
  logic [ACC_W-1:0]  out_data_reg;

  // Buffer ports
  logic [ACC_W-1:0]  acc_mem [DEPTH];
  logic [ACC_W-1:0]  rd_q_reg;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ACC_W-1:0]  wr_data;

  logic              accept;
  logic              pos_ok;
  logic              out_fire;
  logic              drain_adv;
  logic              drain_issue;
  logic              last_beat;
  logic [ACC_W-1:0]  operand;
  logic [ACC_W:0]    sum_wide;
  logic [ACC_W-1:0]  sum_sat;

  assign accept    = (state_reg == ST_ACCUM) && i_valid;
  assign pos_ok    = {{(32 - ADDR_W){1'b0}}, i_pos} < 32'(DEPTH);
  assign out_fire  = out_valid_reg && i_out_ready;
  assign drain_adv = !out_valid_reg || i_out_ready;
  // A new drain read may be issued when the read-data register is free,
  // or when its contents move into the output stage this cycle.
  assign drain_issue = (state_reg == ST_DRAIN) && (fetch_cnt_reg < FETCH_END) &&
                       (drain_adv || !pend_reg);
  assign last_beat = out_fire && (out_pos_reg == LAST_POS);

  // Stage 2: if the previous product hit this position, memory was read
  // before that write landed, so take the forwarded sum instead.
  assign operand  = fwd_reg ? fwd_data_reg : rd_q_reg;
  assign sum_wide = {operand[ACC_W-1], operand} +
                    {{(ACC_W + 1 - DATA_W){s2_data_reg[DATA_W-1]}}, s2_data_reg};

  always_comb begin
    sum_sat = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  // Single write port shared by clear, RMW and drain zeroing. A product
  // accepted alongside i_clear reaches stage 2 inside CLEAR and is dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_reg)
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_addr_reg;
      end
      ST_ACCUM, ST_FLUSH: begin
        wr_en   = s2_valid_reg;
        wr_addr = s2_pos_reg;
        wr_data = sum_sat;
      end
      ST_DRAIN: begin
        wr_en   = out_fire;
        wr_addr = out_pos_reg;
      end
      default: ;
    endcase
  end

  assign rd_en   = (accept && pos_ok) || drain_issue;
  assign rd_addr = (state_reg == ST_DRAIN) ? fetch_cnt_reg[ADDR_W-1:0] : i_pos;

  // Buffer: simple dual-port RAM with a registered read. The read register
  // only updates on rd_en, which holds drain data while the consumer stalls.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      acc_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_q_reg <= acc_mem[rd_addr];
    end
  end

  // FSM next-state and status outputs
  always_comb begin
    state_next = state_reg;
    o_ready    = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        o_busy = 1'b1;
        if (clr_addr_reg == LAST_POS) begin
          state_next = ST_DONE;
        end
      end
      ST_ACCUM: begin
        o_ready = 1'b1;
        if (i_clear) begin
          state_next = ST_CLEAR;
        end else if (i_drain) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Stage 2 is the only in-flight stage and it commits during this
        // cycle, so the pipeline is empty by the next cycle.
        o_busy     = 1'b1;
        state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if (last_beat) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done     = 1'b1;
        state_next = ST_ACCUM;
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_CLEAR;
      clr_addr_reg  <= '0;
      s2_valid_reg  <= 1'b0;
      s2_pos_reg    <= '0;
      s2_data_reg   <= '0;
      fwd_reg       <= 1'b0;
      fwd_data_reg  <= '0;
      fetch_cnt_reg <= '0;
      pend_reg      <= 1'b0;
      pend_pos_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_pos_reg   <= '0;
      out_data_reg  <= '0;
    end else begin
      state_reg <= state_next;

      if (state_reg == ST_CLEAR) begin
        clr_addr_reg <= clr_addr_reg + ADDR_W'(1);
      end else begin
        clr_addr_reg <= '0;
      end

      // Out-of-range positions are accepted but never reach stage 2.
      s2_valid_reg <= accept && pos_ok;
      s2_pos_reg   <= i_pos;
      s2_data_reg  <= i_data;
      fwd_reg      <= s2_valid_reg && (s2_pos_reg == i_pos);
      fwd_data_reg <= sum_sat;

      if (state_reg != ST_DRAIN) begin
        fetch_cnt_reg <= '0;
        pend_reg      <= 1'b0;
        out_valid_reg <= 1'b0;
      end else begin
        if (drain_adv) begin
          out_valid_reg <= pend_reg;
          if (pend_reg) begin
            out_pos_reg  <= pend_pos_reg;
            out_data_reg <= rd_q_reg;
          end
        end
        if (drain_issue) begin
          pend_reg      <= 1'b1;
          pend_pos_reg  <= fetch_cnt_reg[ADDR_W-1:0];
          fetch_cnt_reg <= fetch_cnt_reg + (ADDR_W + 1)'(1);
        end else if (drain_adv) begin
          pend_reg <= 1'b0;
        end
      end
    end
  end

  assign o_out_valid = out_valid_reg;
  assign o_out_pos   = out_pos_reg;
  assign o_out_data  = out_data_reg;

endmodule
